// File: rtl/rca_arb_pkg.sv
// ============================================================================
// rca_arb_pkg : shared constants and FSM state type for the shared-adder arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package rca_arb_pkg;

    localparam int NREQ  = 4;
    localparam int WIDTH = 12;
    localparam int ID_W  = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/RCA_12x12.sv
// ============================================================================
// RCA_12x12 : 12-bit unsigned ripple-carry adder with carry out
// Rev 1.0
// ============================================================================
`default_nettype none

module RCA_12x12
    import rca_arb_pkg::*;
(
    input  logic [11:0] a,
    input  logic [11:0] b,
    output logic [11:0] sum,
    output logic        cout
);

    logic [12:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < 12; i++) begin : g_bit
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[12];

endmodule

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// rr_pick : combinational round-robin winner search starting just after ptr
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_pick
    import rca_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] grant,
    output logic            any_valid
);

    logic [ID_W-1:0] cand;

    // Walk from the farthest candidate back to ptr+1 so the nearest set bit wins.
    always_comb begin
        grant = '0;
        cand  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = ID_W'((int'(ptr) + k) % NREQ);
            if (req[cand]) begin
                grant = cand;
            end
        end
    end

    assign any_valid = |req;

endmodule

`default_nettype wire

// File: rtl/rca12_share_arbiter.sv
// ============================================================================
// rca12_share_arbiter : round-robin sharing of one RCA_12x12 among NREQ requesters
// Rev 1.0
// ============================================================================
`default_nettype none

module rca12_share_arbiter
    import rca_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 12,
    parameter int ID_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_carry,
    output logic [ID_W-1:0]       rsp_id
);

    if (WIDTH != 12) begin : g_width_err
        $error("rca12_share_arbiter: WIDTH must be 12");
    end
    if (NREQ < 2 || NREQ > 8) begin : g_nreq_err
        $error("rca12_share_arbiter: NREQ must be in 2..8");
    end
    if (ID_W != $clog2(NREQ)) begin : g_idw_err
        $error("rca12_share_arbiter: ID_W must equal clog2(NREQ)");
    end

    arb_state_t state;
    arb_state_t state_nxt;

    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  id_q;
    logic [ID_W-1:0]  grant;
    logic             any_valid;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    logic [NREQ-1:0][WIDTH-1:0] req_a_arr;
    logic [NREQ-1:0][WIDTH-1:0] req_b_arr;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign req_a_arr[i] = req_a[i*WIDTH +: WIDTH];
        assign req_b_arr[i] = req_b[i*WIDTH +: WIDTH];
    end

    rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_pick (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .any_valid (any_valid)
    );

    RCA_12x12 u_rca (
        .a    (a_q),
        .b    (b_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_valid) state_nxt = CALC;
            CALC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant is withheld during reset so a reset cycle never looks like a transfer.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && any_valid && !rst) begin
            req_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= ID_W'(NREQ - 1);
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
            rsp_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        a_q  <= req_a_arr[grant];
                        b_q  <= req_b_arr[grant];
                        id_q <= grant;
                        ptr  <= grant;
                    end
                end
                CALC: begin
                    rsp_sum   <= add_sum;
                    rsp_carry <= add_cout;
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rca12_share_arbiter.sv
// ============================================================================
// tb_rca12_share_arbiter : directed + randomized bench against a timing/queue model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rca12_share_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 12;
    localparam int ID_W  = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_carry;
    logic [ID_W-1:0]       rsp_id;

    int errors = 0;
    int checks = 0;

    // Reference model: one outstanding add, result due two cycles after acceptance.
    bit          busy;
    int          acc_cyc;
    int          cyc;
    int          last;
    int          exp_id;
    logic [12:0] exp_res;
    int          granted;

    int          gq[$];
    int          gcyc[$];
    logic [11:0] held_sum;

    always #5 clk = ~clk;

    rca12_share_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .ID_W  (ID_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .rsp_id    (rsp_id)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int rr_winner(input int from, input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(from + k) % NREQ]) return (from + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic v, input logic [11:0] a, input logic [11:0] b);
        req_valid[i]             = v;
        req_a[i*WIDTH +: WIDTH]  = a;
        req_b[i*WIDTH +: WIDTH]  = b;
    endtask

    // Called at a falling edge with inputs already driven; checks, advances model, returns at next falling edge.
    task automatic cycle();
        logic [NREQ-1:0] exp_ready;
        bit              exp_valid;
        int              w;
        #1;
        exp_ready = '0;
        w         = -1;
        exp_valid = busy && (cyc - acc_cyc >= 2);
        if (!busy && !rst) begin
            w = rr_winner(last, req_valid);
            if (w >= 0) exp_ready[w] = 1'b1;
        end
        chk("req_ready", req_ready, exp_ready);
        chk("rsp_valid", rsp_valid, exp_valid);
        if (exp_valid) begin
            chk("rsp_sum", rsp_sum, exp_res[11:0]);
            chk("rsp_carry", rsp_carry, exp_res[12]);
            chk("rsp_id", rsp_id, exp_id);
        end
        granted = -1;
        if (rst) begin
            busy = 1'b0;
            last = NREQ - 1;
        end else if (exp_valid && rsp_ready) begin
            busy = 1'b0;
        end else if (w >= 0) begin
            busy    = 1'b1;
            acc_cyc = cyc;
            last    = w;
            granted = w;
            exp_id  = w;
            exp_res = 13'(req_a[w*WIDTH +: WIDTH]) + 13'(req_b[w*WIDTH +: WIDTH]);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        busy      = 1'b0;
        last      = NREQ - 1;
        cyc       = 0;
        acc_cyc   = 0;
        granted   = -1;
        exp_id    = 0;
        exp_res   = '0;
        @(posedge clk);
        @(negedge clk);
        cycle();
        rst = 1'b0;
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_sum", rsp_sum, 0);
        chk("reset_rsp_carry", rsp_carry, 0);
        chk("reset_rsp_id", rsp_id, 0);
        chk("reset_req_ready", req_ready, 0);

        // 1: simple add on requester 0, result at t+2
        rsp_ready = 1'b1;
        set_req(0, 1'b1, 12'h123, 12'h456);
        cycle();
        chk("t1_granted", granted, 0);
        req_valid = '0;
        cycle();
        chk("t1_valid", rsp_valid, 1);
        chk("t1_sum", rsp_sum, 12'h579);
        chk("t1_carry", rsp_carry, 0);
        chk("t1_id", rsp_id, 0);
        cycle();

        // 2: carry-out boundaries
        set_req(2, 1'b1, 12'hFFF, 12'h001);
        cycle();
        req_valid = '0;
        cycle();
        chk("t2_sum", rsp_sum, 12'h000);
        chk("t2_carry", rsp_carry, 1);
        chk("t2_id", rsp_id, 2);
        cycle();
        set_req(1, 1'b1, 12'hFFF, 12'hFFF);
        cycle();
        req_valid = '0;
        cycle();
        chk("t2b_sum", rsp_sum, 12'hFFE);
        chk("t2b_carry", rsp_carry, 1);
        cycle();

        // 3: all valid, strict rotation with 3-cycle spacing
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 12'($urandom), 12'($urandom));
        rsp_ready = 1'b1;
        gq.delete();
        gcyc.delete();
        for (int n = 0; n < 15; n++) begin
            cycle();
            if (granted >= 0) begin
                gq.push_back(granted);
                gcyc.push_back(cyc);
                set_req(granted, 1'b1, 12'($urandom), 12'($urandom));
            end
        end
        chk("t3_count", gq.size(), 5);
        if (gq.size() == 5) begin
            for (int k = 0; k < 5; k++) begin
                chk("t3_order", gq[k], k % NREQ);
                if (k > 0) chk("t3_spacing", gcyc[k] - gcyc[k-1], 3);
            end
        end
        req_valid = '0;
        repeat (3) cycle();

        // 4: backpressure in RESP
        rsp_ready = 1'b0;
        set_req(3, 1'b1, 12'hA5A, 12'h0F0);
        cycle();
        req_valid = '0;
        cycle();
        held_sum = rsp_sum;
        chk("t4_sum", held_sum, 12'hB4A);
        for (int n = 0; n < 5; n++) begin
            set_req(n % NREQ, 1'b1, 12'($urandom), 12'($urandom));
            cycle();
            chk("t4_hold", rsp_sum, held_sum);
        end
        req_valid = '0;
        set_req(1, 1'b1, 12'h010, 12'h020);
        rsp_ready = 1'b1;
        cycle();
        cycle();
        chk("t4_idle_grant", granted, 1);
        req_valid = '0;
        repeat (2) cycle();

        // 5: reset during CALC discards the add
        do_reset();
        set_req(0, 1'b1, 12'h111, 12'h222);
        cycle();
        req_valid = '0;
        rst       = 1'b1;
        cycle();
        rst = 1'b0;
        chk("t5_no_rsp", rsp_valid, 0);
        req_valid = 4'b1010;
        cycle();
        chk("t5_first", granted, 1);
        req_valid = 4'b1000;
        repeat (2) cycle();

        // 6: wrap-around after requester 3
        do_reset();
        set_req(3, 1'b1, 12'h00F, 12'h001);
        cycle();
        req_valid = '0;
        repeat (2) cycle();
        set_req(0, 1'b1, 12'h800, 12'h800);
        set_req(3, 1'b1, 12'h7FF, 12'h001);
        cycle();
        chk("t6_wrap", granted, 0);
        req_valid[0] = 1'b0;
        repeat (2) cycle();
        cycle();
        chk("t6_next", granted, 3);
        req_valid = '0;
        repeat (3) cycle();

        // Randomized traffic: drops, backpressure and occasional resets
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (granted == i || !req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        set_req(i, 1'b1, 12'($urandom_range(0, 4095)),
                                ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom_range(0, 4095)));
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 9) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
